// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: default widths and the
// fetch state encoding.
package fetch_unit_pkg;

    // Default program-counter and instruction widths of the 16-bit core.
    localparam int PC_W_DEF    = 10;
    localparam int INSTR_W_DEF = 16;

    // Fetch sequencer states.
    //   FS_IDLE  : one-cycle settle after reset, no request
    //   FS_FETCH : request outstanding for the current pc
    //   FS_HOLD  : instruction presented to decode, waiting for consumption
    //   FS_DRAIN : an abandoned request is still outstanding; its data is dropped
    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_HOLD  = 2'd2,
        FS_DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Keeps the program counter, fetches one instruction
// per req/ack handshake from instruction memory and hands it to decode with a
// valid/ready pair. A taken branch redirects the pc to instr_pc + offset and
// flushes whatever instruction is held or in flight. A request that is already
// on the memory bus cannot be withdrawn, so a redirect that arrives before the
// ack parks the sequencer in DRAIN until that ack has been swallowed.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    // instruction memory port
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    // decode port
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    // redirect from the branch unit
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_offset
);

    fetch_state_t       state_reg, state_next;
    logic [PC_W-1:0]    pc_reg, pc_next;
    logic [PC_W-1:0]    drain_addr_reg, drain_addr_next;
    logic [INSTR_W-1:0] instr_reg, instr_next;
    logic [PC_W-1:0]    instr_pc_reg, instr_pc_next;
    logic               instr_valid_reg, instr_valid_next;

    // Both adders are PC_W bits wide, so carries out of the top bit are
    // dropped and the address space wraps silently.
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    branch_target;

    assign pc_inc        = pc_reg + PC_W'(1);
    assign branch_target = instr_pc_reg + branch_offset;

    // Memory port: a request is outstanding in FETCH and DRAIN. While draining,
    // the address must stay that of the abandoned request even though pc has
    // already moved on to the branch target.
    assign imem_req  = (state_reg == FS_FETCH) || (state_reg == FS_DRAIN);
    assign imem_addr = (state_reg == FS_DRAIN) ? drain_addr_reg : pc_reg;

    // Decode port is driven straight from registers.
    assign instr       = instr_reg;
    assign instr_pc    = instr_pc_reg;
    assign instr_valid = instr_valid_reg;

    // State and datapath registers; reset takes effect immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= FS_IDLE;
            pc_reg          <= RESET_PC;
            drain_addr_reg  <= RESET_PC;
            instr_reg       <= '0;
            instr_pc_reg    <= RESET_PC;
            instr_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            drain_addr_reg  <= drain_addr_next;
            instr_reg       <= instr_next;
            instr_pc_reg    <= instr_pc_next;
            instr_valid_reg <= instr_valid_next;
        end
    end

    // Next-state and datapath decisions; a redirect outranks everything
    // except the IDLE settle cycle.
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        drain_addr_next  = drain_addr_reg;
        instr_next       = instr_reg;
        instr_pc_next    = instr_pc_reg;
        instr_valid_next = instr_valid_reg;

        case (state_reg)
            FS_IDLE: begin
                state_next = FS_FETCH;
            end

            FS_FETCH: begin
                if (branch_taken) begin
                    pc_next          = branch_target;
                    instr_valid_next = 1'b0;
                    if (imem_ack) begin
                        // Data for the old path arrived this cycle: drop it
                        // and issue the target request straight away.
                        state_next = FS_FETCH;
                    end else begin
                        // Request still pending: remember its address so the
                        // bus stays stable until the ack drains it.
                        drain_addr_next = pc_reg;
                        state_next      = FS_DRAIN;
                    end
                end else if (imem_ack) begin
                    instr_next       = imem_rdata;
                    instr_pc_next    = pc_reg;
                    instr_valid_next = 1'b1;
                    pc_next          = pc_inc;
                    state_next       = FS_HOLD;
                end
            end

            FS_HOLD: begin
                if (branch_taken) begin
                    // Flush wins over a simultaneous consume.
                    pc_next          = branch_target;
                    instr_valid_next = 1'b0;
                    state_next       = FS_FETCH;
                end else if (instr_ready) begin
                    instr_valid_next = 1'b0;
                    state_next       = FS_FETCH;
                end
            end

            FS_DRAIN: begin
                if (branch_taken) begin
                    // A newer redirect only retargets pc; the abandoned
                    // request is still the one on the bus.
                    pc_next          = branch_target;
                    instr_valid_next = 1'b0;
                end else if (imem_ack) begin
                    state_next = FS_FETCH;
                end
            end

            default: begin
                state_next = FS_IDLE;
            end
        endcase
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 16-bit core, directly upstream of the control unit. Holds the 10-bit program counter, fetches one 16-bit instruction per request from instruction memory over a req/ack handshake, and presents it with valid/ready to decode. Taken branches redirect the PC to `instr_pc + branch_offset`, using the 10-bit offset produced by decode. The redirect flushes the held or in-flight instruction.

## Interface
- `PC_W`, 10: program-counter / instruction-address width; must match the branch-offset width.
- `INSTR_W`, 16: instruction width.
- `RESET_PC`, 10'h000: PC value loaded on reset.

Ports:
- `clk` input 1: the block's single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `imem_req` output 1: read request; held high until `imem_ack`.
- `imem_addr` output PC_W: read address; stable while `imem_req` is high.
- `imem_ack` input 1: read data valid this cycle; ignored when `imem_req` is low.
- `imem_rdata` input INSTR_W: instruction word, sampled on `imem_ack`.
- `instr` output INSTR_W: held instruction, to the control unit.
- `instr_pc` output PC_W: address of `instr`; retains its value after consumption.
- `instr_valid` output 1: `instr` is valid.
- `instr_ready` input 1: downstream consumes `instr` when high together with `instr_valid`.
- `branch_taken` input 1: branch unit resolved a taken branch this cycle.
- `branch_offset` input PC_W: offset from decode, two's complement.

## Operation
- States: IDLE, FETCH, HOLD, DRAIN.
- `imem_req` is high exactly in FETCH and DRAIN. `imem_addr` equals `pc` in FETCH, and the latched address of the abandoned request in DRAIN.

Transitions without a redirect:
- IDLE -> FETCH unconditionally.
- FETCH with `imem_ack`:
  - `instr <= imem_rdata`, `instr_pc <= pc`, `instr_valid <= 1`, `pc <= pc + 1`.
  - Go to HOLD.
- FETCH without ack: stay.
- HOLD with `instr_ready`: `instr_valid <= 0`, go to FETCH.
- HOLD without `instr_ready`: stay; `instr` and `instr_pc` remain stable.
- DRAIN with `imem_ack`: discard `imem_rdata`, go to FETCH.

Redirect (`branch_taken`=1) has priority in every state except IDLE, where it is ignored:
- `pc <= instr_pc + branch_offset`, mod 2^PC_W; wrap-around is silent.
- `instr_valid <= 0`.
- HOLD -> FETCH. Simultaneous `instr_ready` is irrelevant; the flush dominates.
- FETCH with `imem_ack` the same cycle: discard the data, stay in FETCH, and issue to the target next cycle.
- FETCH without ack: go to DRAIN. The outstanding request keeps its original address until acked (memory protocol forbids abandoning a request).
- DRAIN: `pc` updates to the newer target; stay in DRAIN.

PC arithmetic: `pc + 1` and the target add are PC_W-bit with carry discarded, so 10'h3FF + 1 = 10'h000.

## Timing
Reset values:
- State IDLE; `pc` = RESET_PC.
- `imem_req` = 0; `imem_addr` = RESET_PC.
- `instr` = 0; `instr_pc` = RESET_PC; `instr_valid` = 0.

Latency:
- First request is high in the 2nd cycle after reset release (the IDLE cycle comes first).
- `imem_ack` may arrive in the same cycle as `imem_req` rises (zero-wait memory).
- `instr_valid` rises the cycle after the ack.
- Peak throughput with zero-wait memory and `instr_ready` tied high: one instruction per 2 cycles (FETCH, HOLD).

Redirect:
- Takes effect on the next edge. The first target request is visible one cycle after `branch_taken`, or one cycle after the drained ack.

Reset mid-operation:
- Asserting `rst` at any time returns all state and outputs to reset values immediately, without waiting for a clock edge.
- An outstanding memory request is abandoned; instruction memory is reset by the same `rst`.

## Structure
- `defines.vh` gains:
  - `PC_W` and `INSTR_W` default constants.
  - The 2-bit fetch state encodings `FS_IDLE`, `FS_FETCH`, `FS_HOLD`, `FS_DRAIN`.
- Opcode defines there are not used by this block; it does not decode.
- Single module. The target adder and PC incrementer are inline; no sub-module is natural.

## Test plan
- Reset release, zero-wait memory returning 16'h1234 at address 0, `instr_ready`=1 -> `imem_req` high in cycle 2 with addr 0; `instr`=16'h1234, `instr_pc`=0, `instr_valid`=1 in cycle 3; next request to address 1.
- Memory ack delayed 3 cycles, `instr_ready` low 4 cycles -> `imem_addr` stable throughout; `instr` held stable; no new request until the handshake completes.
- HOLD with `instr_pc`=10'h005, `branch_offset`=10'h3FE (−2), `branch_taken` and `instr_ready` both 1 -> `instr_valid` drops; next request address 10'h003.
- Redirect in FETCH before ack (pending addr 7, target 10'h020) -> `imem_req` stays high at addr 7 until ack; data discarded (`instr_valid` stays 0); next request addr 10'h020.
- `pc`=10'h3FF fetch -> next request addr 10'h000; `instr_pc`=10'h3FF with `branch_offset`=10'h002 -> target 10'h001.
- `rst` asserted mid-DRAIN between clock edges -> all outputs take reset values immediately; the fetch restarts at RESET_PC after release.
